data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/batpu_io_pkg.sv | 50 +++++
 rtl/lfsr8.sv | 44 ++++
 rtl/data_mem_responder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/batpu_io_pkg.sv
// ---------------------------------------------------------------------------
// batpu_io_pkg
// Shared definitions for the data-memory responder of the BatPU core:
//   - byte addresses of the memory-mapped I/O registers (240-255)
//   - RAM depth (everything below the I/O window is plain RAM)
//   - display command codes carried on disp_op
//   - LFSR tap mask and a single-step helper used by lfsr8
// ---------------------------------------------------------------------------
package batpu_io_pkg;

  localparam int unsigned RAM_DEPTH = 240;

  localparam logic [7:0] ADDR_PIXEL_X   = 8'd240;
  localparam logic [7:0] ADDR_PIXEL_Y   = 8'd241;
  localparam logic [7:0] ADDR_DRAW      = 8'd242;
  localparam logic [7:0] ADDR_CLRPIX    = 8'd243;
  localparam logic [7:0] ADDR_PIXEL_IN  = 8'd244;
  localparam logic [7:0] ADDR_SCR_PUSH  = 8'd245;
  localparam logic [7:0] ADDR_SCR_CLR   = 8'd246;
  localparam logic [7:0] ADDR_CHAR_WR   = 8'd247;
  localparam logic [7:0] ADDR_CHAR_PUSH = 8'd248;
  localparam logic [7:0] ADDR_CHAR_CLR  = 8'd249;
  localparam logic [7:0] ADDR_NUM_SET   = 8'd250;
  localparam logic [7:0] ADDR_NUM_HIDE  = 8'd251;
  localparam logic [7:0] ADDR_NUM_SIGN  = 8'd252;
  localparam logic [7:0] ADDR_NUM_USIGN = 8'd253;
  localparam logic [7:0] ADDR_RNG       = 8'd254;
  localparam logic [7:0] ADDR_CTRL      = 8'd255;

  // Taps b7, b5, b4, b3 give a maximal-length (255-state) sequence.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Display command codes; DISP_NONE doubles as the reset value of disp_op.
  typedef enum logic [2:0] {
    DISP_NONE      = 3'd0,
    DISP_DRAW      = 3'd1,
    DISP_CLRPIX    = 3'd2,
    DISP_SCR_PUSH  = 3'd3,
    DISP_SCR_CLR   = 3'd4,
    DISP_CHAR_WR   = 3'd5,
    DISP_CHAR_PUSH = 3'd6,
    DISP_CHAR_CLR  = 3'd7
  } disp_op_e;

  // One Fibonacci step: shift left, parity of the tapped bits enters at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] state);
    return {state[6:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// ---------------------------------------------------------------------------
// lfsr8
// 8-bit Fibonacci LFSR used as the random-number source at address 254.
// Ports:
//   clk        in   clock, rising edge
//   sync_rst_n in   synchronous active-low reset, loads SEED
//   step       in   advance one state on this edge
//   value_o    out  current LFSR state
// SEED must be non-zero; the all-zero state is a lock-up state.
// ---------------------------------------------------------------------------
module lfsr8
  import batpu_io_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       sync_rst_n,
  input  logic       step,
  output logic [7:0] value_o
);

  logic [7:0] state_q;
  logic [7:0] state_d;

  // Next state: hold unless asked to step.
  always_comb begin
    state_d = state_q;
    if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  // State register, reloaded with the seed on reset.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign value_o = state_q;

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Answers the core's data-memory port: addresses 0-239 are a 240x8 RAM,
// 240-255 are memory-mapped display, number-display, RNG and controller I/O.
// Ports:
//   clk, sync_rst_n, clk_en      clock, sync active-low reset, global enable
//   mem_req, mem_we              access request and direction (1 = write)
//   data_address, wr_data        byte address and write data
//   rd_data                      registered read data (latency 1)
//   pixel_x, pixel_y, pixel_in   pixel cursor and the pixel value there
//   disp_stb, disp_op            one-cycle display command strobe and code
//   char_code                    last character written
//   num_value, num_show,
//   num_signed                   number display value, enable, signed mode
//   ctrl_in                      controller buttons
// ---------------------------------------------------------------------------
module data_mem_responder
  import batpu_io_pkg::*;
#(
  parameter logic [7:0] RNG_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       sync_rst_n,
  input  logic       clk_en,
  input  logic       mem_req,
  input  logic       mem_we,
  input  logic [7:0] data_address,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic [4:0] pixel_x,
  output logic [4:0] pixel_y,
  input  logic       pixel_in,
  output logic       disp_stb,
  output logic [2:0] disp_op,
  output logic [4:0] char_code,
  output logic [7:0] num_value,
  output logic       num_show,
  output logic       num_signed,
  input  logic [7:0] ctrl_in
);

  // A zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [7:0] SEED_EFF = (RNG_SEED == 8'h00) ? 8'h01 : RNG_SEED;

  logic       accept;
  logic       wrAcc;
  logic       rdAcc;
  logic       isRam;
  logic [7:0] ioRd;
  logic [7:0] lfsrVal;
  disp_op_e   dispCode;

  logic [7:0] mem_q [0:RAM_DEPTH-1];
  logic [7:0] rd_data_q;
  logic [4:0] pixel_x_q,  pixel_x_d;
  logic [4:0] pixel_y_q,  pixel_y_d;
  logic       disp_stb_q, disp_stb_d;
  disp_op_e   disp_op_q,  disp_op_d;
  logic [4:0] char_q,     char_d;
  logic [7:0] num_val_q,  num_val_d;
  logic       num_show_q, num_show_d;
  logic       num_sgn_q,  num_sgn_d;

  // Reset gates acceptance so an access coinciding with reset is dropped.
  assign accept = sync_rst_n & clk_en & mem_req;
  assign wrAcc  = accept & mem_we;
  assign rdAcc  = accept & ~mem_we;
  assign isRam  = (data_address < 8'(RAM_DEPTH));

  lfsr8 #(.SEED(SEED_EFF)) uLfsr (
    .clk        (clk),
    .sync_rst_n (sync_rst_n),
    .step       (rdAcc && (data_address == ADDR_RNG)),
    .value_o    (lfsrVal)
  );

  // I/O read mux; the RNG read returns the pre-step value.
  always_comb begin
    ioRd = 8'h00;
    case (data_address)
      ADDR_PIXEL_IN: ioRd = {7'b0, pixel_in};
      ADDR_RNG:      ioRd = lfsrVal;
      ADDR_CTRL:     ioRd = ctrl_in;
      default:       ioRd = 8'h00;
    endcase
  end

  // Addresses that issue a display command when written.
  always_comb begin
    dispCode = DISP_NONE;
    case (data_address)
      ADDR_DRAW:      dispCode = DISP_DRAW;
      ADDR_CLRPIX:    dispCode = DISP_CLRPIX;
      ADDR_SCR_PUSH:  dispCode = DISP_SCR_PUSH;
      ADDR_SCR_CLR:   dispCode = DISP_SCR_CLR;
      ADDR_CHAR_WR:   dispCode = DISP_CHAR_WR;
      ADDR_CHAR_PUSH: dispCode = DISP_CHAR_PUSH;
      ADDR_CHAR_CLR:  dispCode = DISP_CHAR_CLR;
      default:        dispCode = DISP_NONE;
    endcase
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wrAcc && isRam) begin
      mem_q[data_address] <= wr_data;
    end
  end

  // Read data register with the synchronous RAM read folded in.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      rd_data_q <= 8'h00;
    end else if (rdAcc) begin
      rd_data_q <= isRam ? mem_q[data_address] : ioRd;
    end
  end

  // Next state of the I/O registers; the strobe defaults low every edge.
  always_comb begin
    pixel_x_d  = pixel_x_q;
    pixel_y_d  = pixel_y_q;
    disp_stb_d = 1'b0;
    disp_op_d  = disp_op_q;
    char_d     = char_q;
    num_val_d  = num_val_q;
    num_show_d = num_show_q;
    num_sgn_d  = num_sgn_q;
    if (wrAcc) begin
      case (data_address)
        ADDR_PIXEL_X:   pixel_x_d = wr_data[4:0];
        ADDR_PIXEL_Y:   pixel_y_d = wr_data[4:0];
        ADDR_CHAR_WR:   char_d    = wr_data[4:0];
        ADDR_NUM_SET: begin
          num_val_d  = wr_data;
          num_show_d = 1'b1;
        end
        ADDR_NUM_HIDE:  num_show_d = 1'b0;
        ADDR_NUM_SIGN:  num_sgn_d  = 1'b1;
        ADDR_NUM_USIGN: num_sgn_d  = 1'b0;
        default: ;
      endcase
      if (dispCode != DISP_NONE) begin
        disp_stb_d = 1'b1;
        disp_op_d  = dispCode;
      end
    end
  end

  // I/O register bank.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      pixel_x_q  <= 5'd0;
      pixel_y_q  <= 5'd0;
      disp_stb_q <= 1'b0;
      disp_op_q  <= DISP_NONE;
      char_q     <= 5'd0;
      num_val_q  <= 8'h00;
      num_show_q <= 1'b0;
      num_sgn_q  <= 1'b0;
    end else begin
      pixel_x_q  <= pixel_x_d;
      pixel_y_q  <= pixel_y_d;
      disp_stb_q <= disp_stb_d;
      disp_op_q  <= disp_op_d;
      char_q     <= char_d;
      num_val_q  <= num_val_d;
      num_show_q <= num_show_d;
      num_sgn_q  <= num_sgn_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign pixel_x    = pixel_x_q;
  assign pixel_y    = pixel_y_q;
  assign disp_stb   = disp_stb_q;
  assign disp_op    = disp_op_q;
  assign char_code  = char_q;
  assign num_value  = num_val_q;
  assign num_show   = num_show_q;
  assign num_signed = num_sgn_q;

endmodule
